// File: rtl/uart_rx_core.sv
// 8N1 UART receive engine: synchronises the serial pin, times bits with a
// programmable divisor and presents each byte with sticky ready/overrun flags.
module uart_rx_core #(
  parameter int BAUD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic              clr_rx_rdy,
  output logic [7:0]        rx_data,
  output logic              rx_rdy,
  output logic              frame_err,
  output logic              overrun,
  output logic              rx_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [BAUD_W-1:0]      cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic [BAUD_W-1:0]      n_eff;
  logic [BAUD_W-1:0]      full_reload;
  logic [BAUD_W-1:0]      half_reload;
  logic                   bit_event;

  // Metastability chain; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Divisors below 2 would leave no room for a half-bit wait, so clamp.
  assign n_eff       = (baud_div < BAUD_W'(2)) ? BAUD_W'(2) : baud_div;
  assign full_reload = n_eff - BAUD_W'(1);
  assign half_reload = (n_eff >> 1) - BAUD_W'(1);
  assign bit_event   = (cnt == '0);
  assign rx_busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (clr_rx_rdy) begin
        rx_rdy  <= 1'b0;
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= half_reload;
          end
        end

        START: begin
          if (bit_event) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= full_reload;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - BAUD_W'(1);
          end
        end

        DATA: begin
          if (bit_event) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            cnt     <= full_reload;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt - BAUD_W'(1);
          end
        end

        STOP: begin
          if (bit_event) begin
            // Frame end: a concurrent clear loses to the new byte's ready.
            rx_data   <= shreg;
            frame_err <= ~rxs;
            rx_rdy    <= 1'b1;
            if (rx_rdy && !clr_rx_rdy) begin
              overrun <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - BAUD_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive engine of the UART peripheral. Recovers 8N1 frames from the asynchronous ser_rx pin using a programmable clocks-per-bit divisor.
- Presents each received byte to the MMIO UART wrapper with a sticky ready flag, cleared by the wrapper's getchar read.
- Also reports framing and overrun errors for the status register.

Parameters:
- BAUD_W, 16, width of the clocks-per-bit divisor.
- SYNC_STAGES, 2, number of flops in the RX metastability synchroniser (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  raw serial input (idle high), asynchronous to clk.
- baud_div  input  BAUD_W  clocks per bit, N. Values below 2 are treated as 2.
- clr_rx_rdy  input  1  single-cycle pulse that clears rx_rdy and overrun.
- rx_data  output  8  last received byte (wrapper zero-extends it to 32 bits).
- rx_rdy  output  1  sticky: a new byte is available.
- frame_err  output  1  stop bit of the last frame sampled low. Updated at each frame end.
- overrun  output  1  sticky: a byte completed while rx_rdy was already set.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert):
  - Synchroniser flops reset to 1.
  - State = IDLE, counter = 0, bit index = 0, shift register = 0.
  - rx_data = 0x00; rx_rdy, frame_err, overrun, rx_busy = 0.
- Synchronisation:
  - rx passes through SYNC_STAGES flops. Only the synchronised value rxs is used.
  - rxs lags the pin by SYNC_STAGES cycles.
- Bit timer:
  - Down-counter. An event fires on the cycle the counter equals 0.
  - A full-bit reload loads N-1, so there are N cycles between events.
  - A half-bit reload loads (N>>1)-1.
  - baud_div is sampled at each reload only. A change mid-frame takes effect at the next reload.
- FSM:
  - IDLE: when rxs==0, go to START and do a half-bit reload.
  - START: on event, sample rxs.
    - rxs==1: false start, return to IDLE with no flags changed.
    - rxs==0: go to DATA with a full-bit reload and bit index = 0.
  - DATA: on each event, shift rxs into the shift register MSB and shift right (LSB first on the wire), then increment the bit index and do a full-bit reload. After the 8th sample, go to STOP.
  - STOP: on event, sample rxs.
    - Load rx_data from the shift register.
    - Set frame_err = ~rxs.
    - Set rx_rdy.
    - Return to IDLE.
- Frame end:
  - rx_data, rx_rdy and frame_err update on the clock edge following the stop-bit event cycle.
  - A frame with a framing error still sets rx_rdy and updates rx_data; software checks frame_err.
  - After STOP the FSM is in IDLE with rxs still sampled. A low stop bit (break) will immediately start a new frame when rxs==0 — this is the required behaviour.
- Overrun:
  - If rx_rdy==1 at frame end and clr_rx_rdy is not asserted that cycle, set overrun.
  - rx_data is overwritten by the new byte (newest byte wins).
- Simultaneous clr_rx_rdy and frame end: set wins. rx_rdy stays 1 and overrun is not set.
- clr_rx_rdy otherwise: rx_rdy = 0 and overrun = 0 on the next edge. rx_data and frame_err are unchanged.
- rx_busy is combinational from state (state != IDLE).
- Reset mid-frame discards the partial byte. After release the FSM waits in IDLE for the next falling edge.
- Timing: the nominal sample point is bit centre. The start of frame is detected SYNC_STAGES+1 cycles after the pin edge, and this fixed offset is accepted.

Test Plan:
- N=8, send 0xA5 (8N1, each bit held 8 cycles) -> rx_rdy rises about 76+SYNC cycles after the start edge; rx_data=0xA5, frame_err=0, overrun=0, rx_busy low afterwards.
- N=8, 3-cycle low glitch on idle line -> START sample reads 1, FSM returns to IDLE; rx_rdy, frame_err and rx_data unchanged.
- N=8, send 0x3C with stop bit held 0 -> rx_rdy=1, rx_data=0x3C, frame_err=1. The next good frame 0x81 -> frame_err=0.
- Send 0x11 then 0x22 without clr_rx_rdy -> rx_data=0x22, overrun=1. clr_rx_rdy pulse -> rx_rdy=0, overrun=0.
- Pulse clr_rx_rdy on the exact frame-end cycle of a second byte 0x55 -> rx_rdy=1, rx_data=0x55, overrun=0.
- Assert rst_n low during DATA bit 4 of a frame, release, then send 0x0F with N=2 (baud_div=1 tests clamp to 2) -> no stale byte; rx_data=0x0F, rx_rdy=1.
